opendap_sw_dp_regs: RTL and testbench

- Debug Port register file and AP-access bridge; sits directly downstream of the SW-DP serial comms block.
- Consumes its parallel bus strobe and decodes DP register accesses: DPIDR, CTRL/STAT, SELECT, RDBUFF, ABORT, TARGETID, DLPIDR.
- Supplies the fault, protocol-error and ready qualifiers the comms block samples when it sends ACK.
- Forwards AP accesses over a valid/ready bus with posted-read semantics, tracks sticky error flags and drives power-up requests.

---
 rtl/opendap_sw_dp_regs.sv | 163 ++++++++++++++++
 tb/tb_opendap_sw_dp_regs.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opendap_sw_dp_regs.sv
// SW-DP register file and AP-access bridge: decodes DP register accesses from the
// comms strobe, holds sticky error state and posts AP transfers over valid/ready.
module opendap_sw_dp_regs #(
    parameter logic [31:0] DPIDR     = 32'h0BC12477,
    parameter logic [31:0] TARGETID  = 32'h00000001,
    parameter logic [3:0]  TINSTANCE = 4'h0
) (
    input  logic        swclk,
    input  logic        rst_n,
    input  logic [1:0]  bus_addr,
    input  logic        bus_r_nw,
    input  logic        bus_ap_ndp,
    input  logic [31:0] bus_wdata,
    input  logic        bus_en,
    output logic [31:0] bus_rdata,
    output logic [31:0] targetsel_expected,
    input  logic        dp_set_wdataerr,
    input  logic        dp_set_stickyorun,
    output logic        dp_orundetect,
    output logic        dp_acc_fault,
    output logic        dp_acc_protocol_err,
    output logic        ap_rdy,
    output logic        apbus_en,
    output logic        apbus_wen,
    output logic [7:0]  apbus_sel,
    output logic [7:0]  apbus_addr,
    output logic [31:0] apbus_wdata,
    input  logic        apbus_rdy,
    input  logic [31:0] apbus_rdata,
    input  logic        apbus_err,
    output logic        apbus_abort,
    output logic        cdbgpwrupreq,
    output logic        csyspwrupreq,
    input  logic        cdbgpwrupack,
    input  logic        csyspwrupack
);

    localparam int unsigned DW = 32;

    logic [7:0]    apsel;
    logic [3:0]    apbanksel;
    logic [3:0]    dpbanksel;
    logic [DW-1:0] rdbuff;
    logic          wdataerr;
    logic          readok;
    logic          stickyerr;
    logic          stickyorun;
    logic [1:0]    dbgack_sync;
    logic [1:0]    sysack_sync;
    logic [DW-1:0] ctrl_stat;

    logic dp_wr;
    logic abort_wr;
    logic ctrl_wr;
    logic select_wr;
    logic dap_abort;
    logic ap_issue;
    logic ap_done;

    assign dp_wr     = bus_en && !bus_ap_ndp && !bus_r_nw;
    assign abort_wr  = dp_wr && (bus_addr == 2'd0);
    assign ctrl_wr   = dp_wr && (bus_addr == 2'd1) && (dpbanksel == 4'd0);
    assign select_wr = dp_wr && (bus_addr == 2'd2);
    assign dap_abort = abort_wr && bus_wdata[0];
    // A strobe arriving while a transfer is outstanding is dropped; comms WAITs instead.
    assign ap_issue  = bus_en && bus_ap_ndp && !apbus_en;
    assign ap_done   = apbus_en && apbus_rdy;

    assign ap_rdy              = !apbus_en;
    assign dp_orundetect       = ctrl_stat[0];
    assign targetsel_expected  = {TINSTANCE, TARGETID[27:0]};
    assign dp_acc_fault        = bus_ap_ndp && (stickyerr || stickyorun || wdataerr);
    assign dp_acc_protocol_err = !bus_ap_ndp && !bus_r_nw && (bus_addr == 2'd1)
                                 && (dpbanksel > 4'd1);

    logic orundetect;
    assign ctrl_stat = {sysack_sync[1], csyspwrupreq, dbgack_sync[1], cdbgpwrupreq,
                        20'h0, wdataerr, readok, stickyerr, 3'b000, stickyorun, orundetect};

    // Read data seen by comms during the strobe cycle, i.e. pre-write state.
    always_comb begin
        bus_rdata = '0;
        if (bus_ap_ndp) begin
            bus_rdata = rdbuff;
        end else begin
            case (bus_addr)
                2'd0: bus_rdata = DPIDR;
                2'd1: begin
                    case (dpbanksel)
                        4'd0:    bus_rdata = ctrl_stat;
                        4'd2:    bus_rdata = TARGETID;
                        4'd3:    bus_rdata = {TINSTANCE, 24'h0, 4'h1};
                        default: bus_rdata = '0;
                    endcase
                end
                default: bus_rdata = rdbuff;
            endcase
        end
    end

    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            apbus_en     <= 1'b0;
            apbus_wen    <= 1'b0;
            apbus_sel    <= '0;
            apbus_addr   <= '0;
            apbus_wdata  <= '0;
            apbus_abort  <= 1'b0;
            apsel        <= '0;
            apbanksel    <= '0;
            dpbanksel    <= '0;
            rdbuff       <= '0;
            readok       <= 1'b0;
            stickyerr    <= 1'b0;
            stickyorun   <= 1'b0;
            wdataerr     <= 1'b0;
            orundetect   <= 1'b0;
            cdbgpwrupreq <= 1'b0;
            csyspwrupreq <= 1'b0;
            dbgack_sync  <= '0;
            sysack_sync  <= '0;
        end else begin
            apbus_abort <= dap_abort;
            if (dap_abort) begin
                apbus_en <= 1'b0;
            end else if (ap_issue) begin
                apbus_en    <= 1'b1;
                apbus_wen   <= !bus_r_nw;
                apbus_sel   <= apsel;
                apbus_addr  <= {apbanksel, bus_addr, 2'b00};
                apbus_wdata <= bus_wdata;
            end else if (ap_done) begin
                apbus_en <= 1'b0;
            end

            if (ap_done && !apbus_wen) begin
                rdbuff <= apbus_rdata;
                readok <= !apbus_err;
            end

            // Sticky sets take priority over an ABORT clear in the same cycle.
            stickyerr  <= (stickyerr && !(abort_wr && bus_wdata[2])) || (ap_done && apbus_err);
            wdataerr   <= (wdataerr && !(abort_wr && bus_wdata[3])) || dp_set_wdataerr;
            stickyorun <= (stickyorun && !(abort_wr && bus_wdata[4])) || dp_set_stickyorun;

            if (ctrl_wr) begin
                csyspwrupreq <= bus_wdata[30];
                cdbgpwrupreq <= bus_wdata[28];
                orundetect   <= bus_wdata[0];
            end

            if (select_wr) begin
                apsel     <= bus_wdata[31:24];
                apbanksel <= bus_wdata[7:4];
                dpbanksel <= bus_wdata[3:0];
            end

            dbgack_sync <= {dbgack_sync[0], cdbgpwrupack};
            sysack_sync <= {sysack_sync[0], csyspwrupack};
        end
    end

endmodule

// File: tb/tb_opendap_sw_dp_regs.sv
// Randomized self-checking bench for opendap_sw_dp_regs against a transaction-level
// model of the DP register file and posted AP bridge.
module tb_opendap_sw_dp_regs;

    localparam logic [31:0] DPIDR_V    = 32'h0BC12477;
    localparam logic [31:0] TARGETID_V = 32'h00000001;
    localparam logic [3:0]  TINST_V    = 4'h0;

    logic        swclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  bus_addr = '0;
    logic        bus_r_nw = 1'b0;
    logic        bus_ap_ndp = 1'b0;
    logic [31:0] bus_wdata = '0;
    logic        bus_en = 1'b0;
    logic [31:0] bus_rdata;
    logic [31:0] targetsel_expected;
    logic        dp_set_wdataerr = 1'b0;
    logic        dp_set_stickyorun = 1'b0;
    logic        dp_orundetect;
    logic        dp_acc_fault;
    logic        dp_acc_protocol_err;
    logic        ap_rdy;
    logic        apbus_en;
    logic        apbus_wen;
    logic [7:0]  apbus_sel;
    logic [7:0]  apbus_addr;
    logic [31:0] apbus_wdata;
    logic        apbus_rdy = 1'b0;
    logic [31:0] apbus_rdata = '0;
    logic        apbus_err = 1'b0;
    logic        apbus_abort;
    logic        cdbgpwrupreq;
    logic        csyspwrupreq;
    logic        cdbgpwrupack = 1'b0;
    logic        csyspwrupack = 1'b0;

    opendap_sw_dp_regs dut (
        .swclk(swclk), .rst_n(rst_n),
        .bus_addr(bus_addr), .bus_r_nw(bus_r_nw), .bus_ap_ndp(bus_ap_ndp),
        .bus_wdata(bus_wdata), .bus_en(bus_en), .bus_rdata(bus_rdata),
        .targetsel_expected(targetsel_expected),
        .dp_set_wdataerr(dp_set_wdataerr), .dp_set_stickyorun(dp_set_stickyorun),
        .dp_orundetect(dp_orundetect), .dp_acc_fault(dp_acc_fault),
        .dp_acc_protocol_err(dp_acc_protocol_err), .ap_rdy(ap_rdy),
        .apbus_en(apbus_en), .apbus_wen(apbus_wen), .apbus_sel(apbus_sel),
        .apbus_addr(apbus_addr), .apbus_wdata(apbus_wdata), .apbus_rdy(apbus_rdy),
        .apbus_rdata(apbus_rdata), .apbus_err(apbus_err), .apbus_abort(apbus_abort),
        .cdbgpwrupreq(cdbgpwrupreq), .csyspwrupreq(csyspwrupreq),
        .cdbgpwrupack(cdbgpwrupack), .csyspwrupack(csyspwrupack)
    );

    always #5 swclk = ~swclk;

    int total = 0;
    int bad = 0;

    // Reference model state, updated per completed transaction.
    logic [7:0]  m_apsel;
    logic [3:0]  m_apbank, m_dpbank;
    logic [31:0] m_rdbuff;
    logic m_readok, m_stkerr, m_orun, m_wderr, m_orundet;
    logic m_dbgreq, m_sysreq, m_dbgack, m_sysack;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_apsel = '0; m_apbank = '0; m_dpbank = '0; m_rdbuff = '0;
        m_readok = 0; m_stkerr = 0; m_orun = 0; m_wderr = 0; m_orundet = 0;
        m_dbgreq = 0; m_sysreq = 0; m_dbgack = 0; m_sysack = 0;
    endtask

    function automatic logic [31:0] exp_ctrl();
        return {m_sysack, m_sysreq, m_dbgack, m_dbgreq, 20'h0,
                m_wderr, m_readok, m_stkerr, 3'b000, m_orun, m_orundet};
    endfunction

    function automatic logic [31:0] exp_dp_rdata(input logic [1:0] a);
        if (a == 2'd0) return DPIDR_V;
        if (a != 2'd1) return m_rdbuff;
        case (m_dpbank)
            4'd0:    return exp_ctrl();
            4'd2:    return TARGETID_V;
            4'd3:    return {TINST_V, 24'h0, 4'h1};
            default: return 32'h0;
        endcase
    endfunction

    task automatic dp_read(input logic [1:0] a);
        bus_en = 1; bus_ap_ndp = 0; bus_r_nw = 1; bus_addr = a;
        #1;
        check_eq("dp_rdata", bus_rdata, exp_dp_rdata(a));
        check_eq("rd_perr", 32'(dp_acc_protocol_err), 32'd0);
        @(posedge swclk); #1;
        bus_en = 0;
        @(negedge swclk);
    endtask

    task automatic dp_write(input logic [1:0] a, input logic [31:0] wd,
                            input logic so, input logic sw, input logic rdy_in_abort);
        logic abort;
        abort = (a == 2'd0) && wd[0];
        bus_en = 1; bus_ap_ndp = 0; bus_r_nw = 0; bus_addr = a; bus_wdata = wd;
        dp_set_stickyorun = so; dp_set_wdataerr = sw;
        #1;
        check_eq("wr_perr", 32'(dp_acc_protocol_err), 32'((a == 2'd1) && (m_dpbank > 4'd1)));
        check_eq("wr_fault", 32'(dp_acc_fault), 32'd0);
        @(posedge swclk); #1;
        bus_en = 0; dp_set_stickyorun = 0; dp_set_wdataerr = 0;
        if (rdy_in_abort) begin
            apbus_rdy = 1; apbus_rdata = 32'hDEADBEEF; apbus_err = 1;
        end
        if (a == 2'd0) begin
            if (wd[2]) m_stkerr = 0;
            if (wd[3]) m_wderr = 0;
            if (wd[4]) m_orun = 0;
        end else if (a == 2'd1 && m_dpbank == 4'd0) begin
            m_sysreq = wd[30]; m_dbgreq = wd[28]; m_orundet = wd[0];
        end else if (a == 2'd2) begin
            m_apsel = wd[31:24]; m_apbank = wd[7:4]; m_dpbank = wd[3:0];
        end
        if (so) m_orun = 1;
        if (sw) m_wderr = 1;
        @(negedge swclk);
        check_eq("abort_pulse", 32'(apbus_abort), 32'(abort));
        check_eq("orundetect", 32'(dp_orundetect), 32'(m_orundet));
        check_eq("pwrreqs", {30'h0, csyspwrupreq, cdbgpwrupreq}, {30'h0, m_sysreq, m_dbgreq});
        if (abort) begin
            check_eq("abort_en", 32'(apbus_en), 32'd0);
            check_eq("abort_rdy", 32'(ap_rdy), 32'd1);
            @(posedge swclk); #1;
            apbus_rdy = 0; apbus_err = 0;
            @(negedge swclk);
            check_eq("abort_1cyc", 32'(apbus_abort), 32'd0);
        end
    endtask

    task automatic ap_xfer(input logic rnw, input logic [1:0] a, input logic [31:0] wd,
                           input int stalls, input logic [31:0] rd, input logic err);
        bus_en = 1; bus_ap_ndp = 1; bus_r_nw = rnw; bus_addr = a; bus_wdata = wd;
        #1;
        check_eq("ap_fault", 32'(dp_acc_fault), 32'(m_stkerr | m_orun | m_wderr));
        check_eq("ap_rdy_pre", 32'(ap_rdy), 32'd1);
        if (rnw) check_eq("ap_posted", bus_rdata, m_rdbuff);
        @(posedge swclk); #1;
        bus_en = 0;
        @(negedge swclk);
        check_eq("ap_en_issue", 32'(apbus_en), 32'd1);
        check_eq("ap_rdy_busy", 32'(ap_rdy), 32'd0);
        check_eq("ap_wen", 32'(apbus_wen), 32'(!rnw));
        check_eq("ap_sel", 32'(apbus_sel), 32'(m_apsel));
        check_eq("ap_addr", 32'(apbus_addr), 32'({m_apbank, a, 2'b00}));
        if (!rnw) check_eq("ap_wdata", apbus_wdata, wd);
        for (int i = 0; i < stalls; i++) begin
            @(posedge swclk); #1;
            @(negedge swclk);
            check_eq("ap_en_held", 32'(apbus_en), 32'd1);
            check_eq("ap_addr_held", 32'(apbus_addr), 32'({m_apbank, a, 2'b00}));
        end
        apbus_rdy = 1; apbus_rdata = rd; apbus_err = err;
        @(posedge swclk); #1;
        apbus_rdy = 0; apbus_err = 0;
        if (rnw) begin
            m_rdbuff = rd; m_readok = !err;
        end
        if (err) m_stkerr = 1;
        @(negedge swclk);
        check_eq("ap_en_done", 32'(apbus_en), 32'd0);
        check_eq("ap_rdy_done", 32'(ap_rdy), 32'd1);
    endtask

    task automatic set_flags(input logic so, input logic sw);
        dp_set_stickyorun = so; dp_set_wdataerr = sw;
        @(posedge swclk); #1;
        dp_set_stickyorun = 0; dp_set_wdataerr = 0;
        if (so) m_orun = 1;
        if (sw) m_wderr = 1;
        @(negedge swclk);
    endtask

    task automatic set_acks(input logic d, input logic s);
        cdbgpwrupack = d; csyspwrupack = s;
        @(posedge swclk);
        @(posedge swclk); #1;
        m_dbgack = d; m_sysack = s;
        @(negedge swclk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int op;
        logic [31:0] w;
        model_reset();
        repeat (3) @(negedge swclk);

        // Reset state
        bus_addr = 0; bus_ap_ndp = 0; bus_r_nw = 1;
        #1;
        check_eq("rst_dpidr", bus_rdata, 32'h0BC12477);
        check_eq("rst_tsel", targetsel_expected, 32'h00000001);
        check_eq("rst_apen", 32'(apbus_en), 32'd0);
        check_eq("rst_abort", 32'(apbus_abort), 32'd0);
        check_eq("rst_aprdy", 32'(ap_rdy), 32'd1);
        check_eq("rst_payload", {apbus_sel, apbus_addr, 15'h0, apbus_wen}, 32'h0);
        check_eq("rst_wdata", apbus_wdata, 32'h0);
        check_eq("rst_reqs", {30'h0, csyspwrupreq, cdbgpwrupreq}, 32'h0);
        check_eq("rst_flags", {29'h0, dp_orundetect, dp_acc_fault, dp_acc_protocol_err}, 32'h0);
        rst_n = 1;
        @(negedge swclk);
        dp_read(2'd0);
        dp_read(2'd1);

        // SELECT then AP write with 3 stall cycles
        dp_write(2'd2, 32'h03000010, 0, 0, 0);
        ap_xfer(1'b0, 2'd1, 32'hCAFEF00D, 3, 32'h0, 1'b0);
        check_eq("sel_03", 32'(apbus_sel), 32'h03);
        check_eq("addr_14", 32'(apbus_addr), 32'h14);
        check_eq("wen_1", 32'(apbus_wen), 32'd1);

        // Posted reads
        ap_xfer(1'b1, 2'd0, 32'h0, 0, 32'h12345678, 1'b0);
        bus_en = 1; bus_ap_ndp = 1; bus_r_nw = 1; bus_addr = 2'd0;
        #1;
        check_eq("posted_2nd", bus_rdata, 32'h12345678);
        bus_en = 0;
        ap_xfer(1'b1, 2'd0, 32'h0, 1, 32'h9ABCDEF0, 1'b0);
        dp_read(2'd3);
        check_eq("rdbuff_latest", bus_rdata, 32'h9ABCDEF0);
        dp_read(2'd1);
        check_eq("readok", 32'(bus_rdata[6]), 32'd1);

        // AP error, fault, clear
        ap_xfer(1'b0, 2'd2, 32'h11111111, 0, 32'h0, 1'b1);
        dp_read(2'd1);
        check_eq("stickyerr", 32'(bus_rdata[5]), 32'd1);
        bus_ap_ndp = 1; #1;
        check_eq("fault_set", 32'(dp_acc_fault), 32'd1);
        dp_write(2'd0, 32'h4, 0, 0, 0);
        bus_ap_ndp = 1; #1;
        check_eq("fault_clr", 32'(dp_acc_fault), 32'd0);

        // Overrun and write-data error
        dp_write(2'd1, 32'h50000001, 0, 0, 0);
        check_eq("reqs_hi", {30'h0, csyspwrupreq, cdbgpwrupreq}, 32'h3);
        check_eq("orundet_hi", 32'(dp_orundetect), 32'd1);
        set_flags(1, 1);
        dp_read(2'd1);
        check_eq("orun_wderr", 32'({bus_rdata[7], bus_rdata[1]}), 32'h3);
        dp_write(2'd0, 32'h18, 0, 0, 0);
        dp_read(2'd1);
        check_eq("orun_wderr_clr", 32'({bus_rdata[7], bus_rdata[1]}), 32'h0);
        dp_write(2'd0, 32'h10, 1, 0, 0);
        dp_read(2'd1);
        check_eq("set_beats_clr", 32'(bus_rdata[1]), 32'd1);
        dp_write(2'd0, 32'h10, 0, 0, 0);

        // DAPABORT with an AP read stalled; rdy in the abort cycle is ignored
        bus_en = 1; bus_ap_ndp = 1; bus_r_nw = 1; bus_addr = 2'd3;
        @(posedge swclk); #1;
        bus_en = 0;
        @(negedge swclk);
        check_eq("abort_pre_en", 32'(apbus_en), 32'd1);
        @(posedge swclk); #1;
        @(negedge swclk);
        dp_write(2'd0, 32'h1, 0, 0, 1);
        dp_read(2'd3);
        check_eq("abort_rdbuff", bus_rdata, 32'h9ABCDEF0);

        // Protocol error on DPBANKSEL=2 write
        dp_write(2'd2, 32'h00000002, 0, 0, 0);
        bus_ap_ndp = 0; bus_r_nw = 0; bus_addr = 2'd1; #1;
        check_eq("perr", 32'(dp_acc_protocol_err), 32'd1);
        dp_write(2'd1, 32'hFFFFFFFF, 0, 0, 0);
        dp_read(2'd1);
        dp_write(2'd2, 32'h00000000, 0, 0, 0);

        // Ack synchroniser latency
        bus_ap_ndp = 0; bus_r_nw = 1; bus_addr = 2'd1;
        cdbgpwrupack = 1;
        @(posedge swclk); @(negedge swclk);
        check_eq("ack_1cyc", 32'(bus_rdata[29]), 32'd0);
        @(posedge swclk); @(negedge swclk);
        check_eq("ack_2cyc", 32'(bus_rdata[29]), 32'd1);
        m_dbgack = 1;

        // Randomized traffic against the model
        for (int it = 0; it < 300; it++) begin
            op = int'($urandom_range(0, 8));
            case (op)
                0: ap_xfer(1'b1, 2'($urandom), 32'h0, int'($urandom_range(0, 3)),
                           $urandom, ($urandom_range(0, 7) == 0));
                1: ap_xfer(1'b0, 2'($urandom), $urandom, int'($urandom_range(0, 3)),
                           32'h0, ($urandom_range(0, 7) == 0));
                2: dp_read(2'($urandom));
                3: begin
                    w = $urandom;
                    w[3:0] = 4'($urandom_range(0, 5));
                    dp_write(2'd2, w, 0, 0, 0);
                end
                4: dp_write(2'd1, $urandom, 0, 0, 0);
                5: dp_write(2'd0, $urandom & 32'h1D, 1'($urandom), 1'($urandom), 0);
                6: set_flags(1'($urandom), 1'($urandom));
                7: set_acks(1'($urandom), 1'($urandom));
                default: dp_write(2'd3, $urandom, 0, 0, 0);
            endcase
        end

        // Reset asserted mid-transfer drops apbus_en immediately
        bus_en = 1; bus_ap_ndp = 1; bus_r_nw = 1; bus_addr = 2'd0;
        @(posedge swclk); #1;
        bus_en = 0;
        @(negedge swclk);
        check_eq("mid_en", 32'(apbus_en), 32'd1);
        rst_n = 0;
        #1;
        check_eq("mid_rst_en", 32'(apbus_en), 32'd0);
        check_eq("mid_rst_rdy", 32'(ap_rdy), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
